// File: rtl/dcache_wb_buf.sv
// rtl/dcache_wb_buf.sv - write-back buffer between the dcache and the mem_ctrl dcache port
// Coalescing circular FIFO of dirty blocks; read misses bypass it straight to memory.
`timescale 1ns/1ps
module dcache_wb_buf #(
  parameter int N_ENTRIES = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 64
) (
  input  logic                        clk,
  input  logic                        rst_aH,
  input  logic                        dcache_req_valid,
  input  logic                        dcache_req_type,
  input  logic [ADDR_W-1:0]           dcache_req_block_addr,
  input  logic [DATA_W-1:0]           dcache_req_block_data,
  output logic                        dcache_req_ready,
  output logic                        dcache_resp_valid,
  output logic [DATA_W-1:0]           dcache_resp_block_data,
  output logic                        mem_ctrl_req_valid,
  output logic                        mem_ctrl_req_type,
  output logic [ADDR_W-1:0]           mem_ctrl_req_block_addr,
  output logic [DATA_W-1:0]           mem_ctrl_req_block_data,
  input  logic                        mem_ctrl_req_ready,
  input  logic                        mem_ctrl_resp_valid,
  input  logic [DATA_W-1:0]           mem_ctrl_resp_block_data,
  output logic [$clog2(N_ENTRIES):0]  wb_count,
  output logic                        wb_empty
);
  localparam int PTR_W = $clog2(N_ENTRIES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] IDLE = 2'd0, WR_REQ = 2'd1, RD_REQ = 2'd2, RD_WAIT = 2'd3;
  localparam logic REQ_RD = 1'b0, REQ_WR = 1'b1;

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [N_ENTRIES];
  logic [DATA_W-1:0] data_q [N_ENTRIES];
  logic [N_ENTRIES-1:0] vld_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              hit_resp_q, hit_resp_d;
  logic [DATA_W-1:0] hit_data_q, hit_data_d;

  logic             hit, full, accept, acc_wr, acc_rd, enq, coalesce, pop;
  logic [PTR_W-1:0] hit_idx;

  // Coalescing guarantees at most one valid entry per address.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (vld_q[i] && addr_q[i] == dcache_req_block_addr) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign full = (count_q == CNT_W'(N_ENTRIES));

  // While the head is on the bus it must not change, so writes to it stall.
  always_comb begin
    dcache_req_ready = 1'b0;
    if (!rst_aH) begin
      case (state_q)
        IDLE:    dcache_req_ready = (dcache_req_type == REQ_RD) || hit || !full;
        WR_REQ:  dcache_req_ready = (dcache_req_type == REQ_WR) && (hit ? (hit_idx != head_q) : !full);
        default: dcache_req_ready = 1'b0;
      endcase
    end
  end

  assign accept   = dcache_req_valid && dcache_req_ready;
  assign acc_wr   = accept && (dcache_req_type == REQ_WR);
  assign acc_rd   = accept && (dcache_req_type == REQ_RD);
  assign coalesce = acc_wr && hit;
  assign enq      = acc_wr && !hit;
  assign pop      = (state_q == WR_REQ) && mem_ctrl_req_ready;

  always_comb begin
    mem_ctrl_req_valid      = 1'b0;
    mem_ctrl_req_type       = REQ_RD;
    mem_ctrl_req_block_addr = '0;
    mem_ctrl_req_block_data = '0;
    if (!rst_aH) begin
      case (state_q)
        WR_REQ: begin
          mem_ctrl_req_valid      = 1'b1;
          mem_ctrl_req_type       = REQ_WR;
          mem_ctrl_req_block_addr = addr_q[head_q];
          mem_ctrl_req_block_data = data_q[head_q];
        end
        RD_REQ: begin
          mem_ctrl_req_valid      = 1'b1;
          mem_ctrl_req_block_addr = rd_addr_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dcache_resp_valid      = 1'b0;
    dcache_resp_block_data = '0;
    if (!rst_aH) begin
      if (state_q == RD_WAIT && mem_ctrl_resp_valid) begin
        dcache_resp_valid      = 1'b1;
        dcache_resp_block_data = mem_ctrl_resp_block_data;
      end else begin
        dcache_resp_valid      = hit_resp_q;
        dcache_resp_block_data = hit_data_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    hit_resp_d = 1'b0;
    hit_data_d = '0;
    case (state_q)
      IDLE: begin
        if (acc_rd) begin
          if (hit) begin
            hit_resp_d = 1'b1;
            hit_data_d = data_q[hit_idx];
          end else begin
            state_d   = RD_REQ;
            rd_addr_d = dcache_req_block_addr;
          end
        end else if (count_q != '0) begin
          state_d = WR_REQ;
        end
      end
      WR_REQ:  if (mem_ctrl_req_ready) state_d = IDLE;
      RD_REQ:  if (mem_ctrl_req_ready) state_d = RD_WAIT;
      RD_WAIT: if (mem_ctrl_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign head_d  = head_q + PTR_W'(pop);
  assign tail_d  = tail_q + PTR_W'(enq);
  assign count_d = count_q + CNT_W'(enq) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (rst_aH) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      vld_q      <= '0;
      rd_addr_q  <= '0;
      hit_resp_q <= 1'b0;
      hit_data_q <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rd_addr_q  <= rd_addr_d;
      hit_resp_q <= hit_resp_d;
      hit_data_q <= hit_data_d;
      if (enq) begin
        addr_q[tail_q] <= dcache_req_block_addr;
        data_q[tail_q] <= dcache_req_block_data;
        vld_q[tail_q]  <= 1'b1;
      end
      if (coalesce) data_q[hit_idx] <= dcache_req_block_data;
      if (pop) vld_q[head_q] <= 1'b0;
    end
  end

  assign wb_count = count_q;
  assign wb_empty = (count_q == '0);
endmodule

// File: doc/dcache_wb_buf.md
DCACHE_WB_BUF -- requirements
Module: dcache_wb_buf

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 2, write-back FIFO depth (power of 2, >=2).
REQ-002 SHALL have ports clk, in, 1, clock; all state updates on the rising edge.
REQ-003 SHALL have ports rst_aH, in, 1; one clock, reset is synchronous and active-high.
REQ-004 SHALL have dcache_req_valid, in, 1, request from dcache.
REQ-005 SHALL have dcache_req_type, in, req_type_t, 0 read / 1 write.
REQ-006 SHALL have dcache_req_block_addr, in, main_mem_block_addr_t, block address.
REQ-007 SHALL have dcache_req_block_data, in, block_data_t, write data.
REQ-008 SHALL have dcache_req_ready, out, 1, request accepted when valid&ready.
REQ-009 SHALL have dcache_resp_valid and dcache_resp_block_data, out, 1 and block_data_t, read response to dcache.
REQ-010 SHALL have mem_ctrl_req_valid, mem_ctrl_req_type, mem_ctrl_req_block_addr and mem_ctrl_req_block_data as outputs, widths as REQ-004..007, toward mem_ctrl dcache port.
REQ-011 SHALL have mem_ctrl_req_ready, in, 1, mem_ctrl accepts request.
REQ-012 SHALL have mem_ctrl_resp_valid and mem_ctrl_resp_block_data, in, 1 and block_data_t, read response from mem_ctrl.
REQ-013 SHALL have wb_count, out, clog2(N_ENTRIES)+1, occupied entries; wb_empty, out, 1, wb_count==0.

Function
REQ-014 SHALL hold a circular FIFO of {addr, data, valid} with head/tail pointers wrapping modulo N_ENTRIES.
REQ-015 SHALL implement FSM states IDLE, WR_REQ, RD_REQ, RD_WAIT.
REQ-016 SHALL assert dcache_req_ready only in IDLE; exception per REQ-019.
REQ-017 Accepted write, addr matches no valid entry, FIFO not full: enqueue at tail, count+1 next cycle, no dcache response.
REQ-018 Accepted write, addr matches a valid entry: overwrite that entry's data in place (coalesce), count unchanged; accepted even when full.
REQ-019 In WR_REQ, dcache_req_ready SHALL be 1 only for a write that coalesces into a non-head entry or enqueues into a non-full FIFO; any write hitting the head entry, and all reads, stall (ready=0).
REQ-020 Write with full FIFO and no match: ready=0.
REQ-021 Accepted read hitting a valid entry: dcache_resp_valid=1 exactly one cycle later with that entry's data; no mem_ctrl request; stays IDLE.
REQ-022 Accepted read missing all entries: IDLE->RD_REQ; mem_ctrl_req_valid=1, type=read, addr captured; reads bypass buffered writes (addresses disjoint).
REQ-023 RD_REQ->RD_WAIT on mem_ctrl_req_valid&mem_ctrl_req_ready.
REQ-024 RD_WAIT: on mem_ctrl_resp_valid, drive dcache_resp_valid=1 same cycle with mem_ctrl_resp_block_data; ->IDLE next cycle.
REQ-025 IDLE with no accepted dcache read and FIFO non-empty: ->WR_REQ presenting head entry (type=write) next cycle; a read accepted the same cycle takes priority (REQ-022).
REQ-026 WR_REQ: valid, addr, data SHALL stay stable until mem_ctrl_req_ready; on handshake pop head (count-1, head+1), ->IDLE.
REQ-027 Simultaneous enqueue (REQ-019) and pop same cycle: count unchanged, both pointers advance.
REQ-028 mem_ctrl_resp_valid outside RD_WAIT SHALL be ignored.
REQ-029 dcache_resp_valid SHALL be a single-cycle pulse per accepted read; never asserted for writes.
REQ-030 mem_ctrl_req_valid SHALL be 0 in IDLE and RD_WAIT.

Reset
REQ-031 rst_aH high at a clock edge: state=IDLE, head=tail=0, count=0, all valid bits 0, wb_empty=1.
REQ-032 During/after reset: dcache_req_ready=0 while rst_aH=1, mem_ctrl_req_valid=0, dcache_resp_valid=0, data outputs 0.
REQ-033 Reset mid-operation (WR_REQ/RD_WAIT) SHALL discard buffered writes and outstanding read; later mem_ctrl response ignored.

Verification
REQ-034 Write addr 0x10 data A, mem_ctrl_req_ready=0 -> count=1, WR_REQ, req addr 0x10 data A held stable 5 cycles; ready=1 -> count=0, IDLE.
REQ-035 Writes 0x10 A, 0x20 B (ready=0), third write 0x30 -> dcache_req_ready=0 (full); write 0x20 C -> accepted, count=2, drained entry 0x20 carries C.
REQ-036 Buffered 0x20 B, read 0x20 -> dcache_resp_valid next cycle, data B, no mem_ctrl read issued.
REQ-037 Read 0x40 miss, mem_ctrl ready after 2 cycles, resp 3 cycles later with D -> dcache_resp D same cycle as mem_ctrl_resp_valid, back to IDLE.
REQ-038 FIFO wrap: 5 write/drain pairs with N_ENTRIES=2 -> FIFO order preserved, pointers wrap, count returns 0.
REQ-039 rst_aH pulsed in WR_REQ with count=2 -> next cycle count=0, mem_ctrl_req_valid=0, wb_empty=1.
